// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Fetch stage between the instruction pointer and the decoder. Reads the
// current IP and issues a word read to instruction memory. It holds the
// returned word for the decoder on a valid/ready handshake. When the decoder
// accepts the word, it drives the IP adjust/update inputs with +1 or with a
// signed branch offset.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   When defined, a request left unacknowledged for TIMEOUT_CYCLES cycles
//   drops mem_req, raises the sticky fault flag and parks the stage in the
//   terminal FAULT state until reset. When undefined, REQ waits
//   indefinitely and fault is tied to 0.
//
// Handshake semantics:
//   memory : mem_req is held high, with mem_addr = ip, until the cycle in
//            which mem_ack=1. mem_data is captured in that cycle. mem_ack
//            outside REQ is ignored.
//   decoder: instr/instr_valid stay stable until instr_valid & instr_ready
//            (accept). ip_update and ip_adj are asserted combinationally
//            only in the accept cycle.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   run                   allow new fetches
//   ip                    current instruction pointer
//   mem_addr/mem_req      memory read address / request
//   mem_ack/mem_data      memory data valid / read data
//   instr/instr_valid     fetched word to decoder / valid
//   instr_ready           decoder accepts instr
//   branch/branch_adj     accepted instr redirects IP by signed branch_adj
//   ip_adj/ip_update      signed IP adjustment / update strobe
//   fault                 sticky fetch timeout flag
//   dbg_state             current FSM state (0 IDLE, 1 REQ, 2 HOLD, 3 FAULT)
// WORD_SIZE defaults to the project-wide word width used in parameters.v.
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int WORD_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [WORD_SIZE-1:0] ip,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic                 mem_req,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic [WORD_SIZE-1:0] instr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 branch,
  input  logic [WORD_SIZE-1:0] branch_adj,
  output logic [WORD_SIZE-1:0] ip_adj,
  output logic                 ip_update,
  output logic                 fault,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  // A zero-cycle timeout would make every request fault immediately.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("instr_fetch: TIMEOUT_CYCLES must be at least 1");
  end

  state_t state, next;
  logic   accept;
  logic   timeout_hit;

  assign accept = (state == S_HOLD) && instr_ready;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counts the REQ cycles already elapsed. It is zero in every other
  // state, so it is zero on every entry to REQ.
  logic [CNT_W-1:0] req_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      req_cnt <= '0;
    else if (state == S_REQ)
      req_cnt <= req_cnt + CNT_W'(1);
    else
      req_cnt <= '0;
  end

  // This is the last permitted REQ cycle. It only matters if no ack arrives.
  assign timeout_hit = (state == S_REQ) && (req_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= next;
  end

  // Next-state logic
  always_comb begin
    next = state;
    case (state)
      S_IDLE: if (run) next = S_REQ;
      // run is deliberately not checked: an issued request always completes.
      S_REQ: begin
        if (mem_ack)
          next = S_HOLD;
        else if (timeout_hit)
          next = S_FAULT;
      end
      S_HOLD: if (accept) next = run ? S_REQ : S_IDLE;
`ifdef FETCH_TIMEOUT_EN
      S_FAULT: next = S_FAULT;
`endif
      default: next = S_IDLE;
    endcase
  end

  // Fetched-word register: loaded only on the acknowledged REQ cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      instr <= '0;
    else if ((state == S_REQ) && mem_ack)
      instr <= mem_data;
  end

  // Output logic
  always_comb begin
    mem_req     = (state == S_REQ);
    mem_addr    = (state == S_REQ) ? ip : '0;
    instr_valid = (state == S_HOLD);
    ip_update   = accept;
    ip_adj      = '0;
    if (accept)
      ip_adj = branch ? branch_adj : ONE;
`ifdef FETCH_TIMEOUT_EN
    fault       = (state == S_FAULT);
`else
    fault       = 1'b0;
`endif
    dbg_state   = state;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch.
//
// The bench contains an IP register that adds ip_adj on ip_update and can be
// loaded directly. It also models a memory that returns mem_word(addr).
//
// The bench runs three kinds of checks:
//   - hand-written sequences for reset, stall, branch, run drop, reset
//     during a request, and timeout;
//   - a table of accept vectors, including address wrap;
//   - randomized transactions, checked against an address-stream model
//     and an expected-word queue.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
  localparam int W  = 16;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         run = 1'b0, mem_ack = 1'b0, instr_ready = 1'b0, branch = 1'b0;
  logic [W-1:0] ip, mem_data = '0, branch_adj = '0;
  logic [W-1:0] mem_addr, instr, ip_adj;
  logic         mem_req, instr_valid, ip_update, fault;
  logic [1:0]   dbg_state;
  logic         ip_load = 1'b0;
  logic [W-1:0] ip_load_val = '0;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  instr_fetch #(.WORD_SIZE(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .run(run), .ip(ip),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch(branch), .branch_adj(branch_adj), .ip_adj(ip_adj),
    .ip_update(ip_update), .fault(fault), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  // IP register of the surrounding core.
  always @(posedge clk or posedge reset) begin
    if (reset)          ip <= '0;
    else if (ip_load)   ip <= ip_load_val;
    else if (ip_update) ip <= ip + ip_adj;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 16'd40503) ^ 16'h5A5A;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    branch = 1'b0; branch_adj = '0; ip_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) begin ok = 1'b1; break; end
      cyc();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_wait actual=no_request required=mem_req within 40 cycles");
    end
  endtask

  task automatic ack_now(input logic [W-1:0] d);
    mem_ack = 1'b1; mem_data = d;
    cyc();
    mem_ack = 1'b0;
  endtask

  task automatic accept(input logic br, input logic [W-1:0] adj, input logic [W-1:0] exp_adj);
    instr_ready = 1'b1; branch = br; branch_adj = adj;
    #1;
    chk("acc_update", ip_update, 1);
    chk("acc_adj", ip_adj, exp_adj);
    cyc();
    instr_ready = 1'b0; branch = 1'b0;
  endtask

  task automatic load_ip(input logic [W-1:0] v);
    ip_load = 1'b1; ip_load_val = v;
    cyc();
    ip_load = 1'b0;
  endtask

  // ---------------- accept vector table ----------------
  typedef struct {
    logic         br;
    logic [W-1:0] adj;
    logic [W-1:0] start_ip;
    logic [W-1:0] data;
    logic [W-1:0] exp_adj;
    logic [W-1:0] exp_next;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{br: 1'b0, adj: 16'h0040, start_ip: 16'h0005, data: 16'hA001, exp_adj: 16'h0001, exp_next: 16'h0006};
    vecs[1] = '{br: 1'b1, adj: 16'h0010, start_ip: 16'h0020, data: 16'hA002, exp_adj: 16'h0010, exp_next: 16'h0030};
    vecs[2] = '{br: 1'b1, adj: 16'hFFFF, start_ip: 16'h0000, data: 16'hA003, exp_adj: 16'hFFFF, exp_next: 16'hFFFF};
    vecs[3] = '{br: 1'b0, adj: 16'h0000, start_ip: 16'hFFFF, data: 16'hA004, exp_adj: 16'h0001, exp_next: 16'h0000};
    vecs[4] = '{br: 1'b1, adj: 16'h8000, start_ip: 16'h1234, data: 16'hA005, exp_adj: 16'h8000, exp_next: 16'h9234};
    vecs[5] = '{br: 1'b1, adj: 16'h0000, start_ip: 16'h0777, data: 16'hA006, exp_adj: 16'h0000, exp_next: 16'h0777};

    // ---- 1: reset values, first fetch, sequential accept ----
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_update", ip_update, 0);
    chk("rst_fault", fault, 0);
    chk("rst_instr", instr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_adj", ip_adj, 0);
    chk("rst_state", dbg_state, 0);
    do_reset();
    chk("idle_no_req", mem_req, 0);
    run = 1'b1;
    cyc();
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 16'h0000);
    ack_now(16'h0011);
    chk("t1_valid", instr_valid, 1);
    chk("t1_instr", instr, 16'h0011);
    chk("t1_req_off", mem_req, 0);
    accept(1'b0, 16'h0000, 16'h0001);
    chk("t1_next_req", mem_req, 1);
    chk("t1_next_addr", mem_addr, 16'h0001);

    // ---- 2: decoder stall, with branch and stray ack ignored ----
    ack_now(16'h0022);
    for (int i = 0; i < 5; i++) begin
      branch = 1'b1; branch_adj = 16'h0055;
      mem_ack = 1'b1; mem_data = 16'hDEAD;
      #1;
      chk("t2_valid", instr_valid, 1);
      chk("t2_instr", instr, 16'h0022);
      chk("t2_update", ip_update, 0);
      chk("t2_adj", ip_adj, 0);
      cyc();
    end
    mem_ack = 1'b0; branch = 1'b0;
    chk("t2_instr_after", instr, 16'h0022);
    accept(1'b0, 16'h0000, 16'h0001);
    chk("t2_next_addr", mem_addr, 16'h0002);

    // ---- 3: backward branch from ip=10 ----
    load_ip(16'd10);
    chk("t3_addr", mem_addr, 16'd10);
    ack_now(16'h0033);
    accept(1'b1, 16'hFFFD, 16'hFFFD);
    chk("t3_branch_addr", mem_addr, 16'd7);

    // ---- 4: run dropped during REQ ----
    run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t4_req_held", mem_req, 1);
      cyc();
    end
    ack_now(16'h0044);
    chk("t4_valid", instr_valid, 1);
    chk("t4_instr", instr, 16'h0044);
    accept(1'b0, 16'h0000, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      chk("t4_idle_req", mem_req, 0);
      chk("t4_idle_state", dbg_state, 0);
      cyc();
    end
    run = 1'b1;
    cyc();
    chk("t4_resume_req", mem_req, 1);
    chk("t4_resume_addr", mem_addr, 16'd8);
    // branch by zero refetches the same address
    ack_now(16'h0055);
    accept(1'b1, 16'h0000, 16'h0000);
    chk("t4_refetch_addr", mem_addr, 16'd8);

    // ---- 5: reset during a request, then a stray ack ----
    reset = 1'b1;
    #1;
    chk("t5_req_drop", mem_req, 0);
    chk("t5_valid_drop", instr_valid, 0);
    cyc();
    run = 1'b0;
    reset = 1'b0;
    mem_ack = 1'b1; mem_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_stray_valid", instr_valid, 0);
      chk("t5_stray_req", mem_req, 0);
      chk("t5_stray_instr", instr, 0);
    end
    mem_ack = 1'b0;

    // ---- 6: no ack for TIMEOUT cycles ----
    run = 1'b1;
    cyc();
    for (int i = 0; i < TO; i++) begin
      chk("t6_req_wait", mem_req, 1);
      chk("t6_no_fault", fault, 0);
      cyc();
    end
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1'b1; instr_ready = 1'b1;
      #1;
      chk("t6_fault_req", mem_req, 0);
      chk("t6_fault", fault, 1);
      chk("t6_fault_upd", ip_update, 0);
      cyc();
    end
    mem_ack = 1'b0; instr_ready = 1'b0;
`else
    for (int i = 0; i < 5; i++) begin
      chk("t6_req_stays", mem_req, 1);
      chk("t6_fault_zero", fault, 0);
      cyc();
    end
`endif

    // ---- accept vector table ----
    do_reset();
    run = 1'b1;
    cyc();
    for (int v = 0; v < 6; v++) begin
      load_ip(vecs[v].start_ip);
      chk("tbl_addr", mem_addr, vecs[v].start_ip);
      ack_now(vecs[v].data);
      chk("tbl_instr", instr, vecs[v].data);
      accept(vecs[v].br, vecs[v].adj, vecs[v].exp_adj);
      chk("tbl_next_addr", mem_addr, vecs[v].exp_next);
    end

    // ---- randomized transactions against the address-stream model ----
    begin
      logic [W-1:0] exp_addr;
      logic [W-1:0] exp_word;
      logic [W-1:0] adj;
      logic         br;
      do_reset();
      exp_addr = '0;
      for (int t = 0; t < 200; t++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) cyc();
        run = 1'b1;
        wait_req();
        chk("rnd_addr", mem_addr, exp_addr);
        exp_q.push_back(mem_word(exp_addr));
        for (int l = $urandom_range(0, 3); l > 0; l--) begin
          run = ($urandom_range(0, 3) != 0);
          cyc();
        end
        ack_now(mem_word(mem_addr));
        exp_word = exp_q.pop_front();
        for (int l = $urandom_range(0, 3); l > 0; l--) begin
          mem_ack = $urandom_range(0, 1); mem_data = W'($urandom);
          run = ($urandom_range(0, 3) != 0);
          #1;
          chk("rnd_hold_instr", instr, exp_word);
          chk("rnd_hold_upd", ip_update, 0);
          cyc();
        end
        mem_ack = 1'b0;
        chk("rnd_instr", instr, exp_word);
        chk("rnd_valid", instr_valid, 1);
        br  = $urandom_range(0, 1);
        adj = W'($urandom);
        run = ($urandom_range(0, 3) != 0);
        accept(br, adj, br ? adj : W'(1));
        exp_addr = exp_addr + (br ? adj : W'(1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
